mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width in bits.
REQ-003 The block SHALL have ports as follows:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction-fetch request; held until if_gnt.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  registered fetch data.
- if_gnt  out  1  one-cycle pulse; fetch complete, if_rdata valid.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  registered load data.
- d_done  out  1  one-cycle pulse; data access complete.
- mem_req  out  1  registered memory request.
- mem_we  out  1  registered write strobe.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion; one cycle.
- stall  out  1  combinational; equals (if_req & ~if_gnt) | (d_req & ~d_done); drives pipeline-register enables low.

Function
REQ-004 The FSM SHALL have states IDLE, GRANT_IF, GRANT_D and RESP.
REQ-005 In IDLE with d_req=1, the block SHALL latch d_we/d_addr/d_wdata into mem_* and go to GRANT_D.
REQ-006 In IDLE with d_req=0 and if_req=1, the block SHALL latch if_addr, set mem_we=0 and go to GRANT_IF.
REQ-007 mem_req SHALL equal 1 exactly while in GRANT_IF or GRANT_D; mem_we/mem_addr/mem_wdata SHALL stay stable during those states.
REQ-008 On mem_ack in GRANT_IF, the block SHALL capture mem_rdata into if_rdata and go to RESP, tagged fetch.
REQ-009 On mem_ack in GRANT_D, the block SHALL capture mem_rdata into d_rdata (loads only; d_rdata unchanged for stores) and go to RESP, tagged data.
REQ-010 In RESP, the block SHALL pulse the tagged if_gnt or d_done for exactly one cycle and return to IDLE.
REQ-011 Minimum latency SHALL be 3 cycles from request sampled in IDLE to the gnt/done pulse, with mem_ack in the first grant cycle; each additional wait cycle adds one.
REQ-012 mem_ack in IDLE or RESP SHALL be ignored.
REQ-013 A request deasserted mid-transaction SHALL NOT abort it; the access completes and the pulse is still issued.
REQ-014 At most one memory transaction SHALL be outstanding; the earliest new grant after a completion is the IDLE cycle following RESP.
REQ-015 if_gnt and d_done SHALL never be asserted in the same cycle.

Reset
REQ-016 rst=0 SHALL immediately force state=IDLE and mem_req, mem_we, if_gnt, d_done to 0; mem_addr, mem_wdata, if_rdata, d_rdata to 0; internal priority flag to 0.
REQ-017 Reset asserted mid-transaction SHALL discard it with no gnt/done pulse; operation resumes in IDLE on the first clock after rst=1.

Configuration
REQ-018 With macro ARB_FAIR_EN defined, a flag set on each data completion SHALL make the next IDLE arbitration with both requests pending select fetch, after which the flag clears; the flag clears on any fetch grant.
REQ-019 Without ARB_FAIR_EN, data SHALL always win simultaneous requests (fixed priority) and the flag logic SHALL not exist.

Verification
REQ-020 The bench SHALL cover these scenarios:
- if_req=1, if_addr=0x100, mem_ack in first grant cycle with mem_rdata=0x00500093 -> mem_req high 1 cycle, if_gnt pulse on cycle 3 with if_rdata=0x00500093.
- d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, ack delayed 4 cycles -> mem_we=1 and mem_addr/mem_wdata stable 5 cycles, d_done pulse, d_rdata unchanged, stall high until done.
- if_req and d_req held continuously, immediate acks -> without ARB_FAIR_EN data completes first; with it, order D, IF, D, IF.
- rst=0 asynchronously during GRANT_D -> mem_req=0 immediately, no d_done; after release, fetch request served normally.
- mem_ack pulsed while in IDLE with no request -> no state change, no pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master memory port arbiter: instruction fetch and data share one memory port.
// Define ARB_FAIR_EN to alternate fetch/data on contention; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_gnt,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall
);

    // state    | meaning
    // IDLE     | no access in flight; arbitrate pending requests
    // GRANT_IF | fetch access presented on mem_*, waiting for mem_ack
    // GRANT_D  | data access presented on mem_*, waiting for mem_ack
    // RESP     | one-cycle completion pulse to the tagged master
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_D  = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   resp_is_d_q;
    logic   resp_is_d_d;
    logic   sel_d;
    logic   sel_if;
    logic   start_d;
    logic   start_if;

`ifdef ARB_FAIR_EN
    logic fair_q;

    always_comb begin
        sel_d  = 1'b0;
        sel_if = 1'b0;
        if (d_req && !(fair_q && if_req)) begin
            sel_d = 1'b1;
        end else if (if_req) begin
            sel_if = 1'b1;
        end
    end
`else
    always_comb begin
        sel_d  = 1'b0;
        sel_if = 1'b0;
        if (d_req) begin
            sel_d = 1'b1;
        end else if (if_req) begin
            sel_if = 1'b1;
        end
    end
`endif

    assign start_d  = (state_q == IDLE) && sel_d;
    assign start_if = (state_q == IDLE) && sel_if;

    always_comb begin
        state_d     = state_q;
        resp_is_d_d = resp_is_d_q;
        case (state_q)
            IDLE: begin
                if (sel_d) begin
                    state_d = GRANT_D;
                end else if (sel_if) begin
                    state_d = GRANT_IF;
                end
            end
            GRANT_IF: begin
                if (mem_ack) begin
                    state_d     = RESP;
                    resp_is_d_d = 1'b0;
                end
            end
            GRANT_D: begin
                if (mem_ack) begin
                    state_d     = RESP;
                    resp_is_d_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            resp_is_d_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_is_d_q <= resp_is_d_d;
        end
    end

    // Completion pulses decode straight from RESP so reset kills them instantly.
    assign if_gnt = (state_q == RESP) && !resp_is_d_q;
    assign d_done = (state_q == RESP) &&  resp_is_d_q;
    assign stall  = (if_req && !if_gnt) || (d_req && !d_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (state_d == GRANT_IF) || (state_d == GRANT_D);
            if (start_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (start_if) begin
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end
        end
    end

    // Store completions leave d_rdata holding the last load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if ((state_q == GRANT_IF) && mem_ack) begin
                if_rdata <= mem_rdata;
            end
            if ((state_q == GRANT_D) && mem_ack && !mem_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

`ifdef ARB_FAIR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fair_q <= 1'b0;
        end else if (start_if) begin
            fair_q <= 1'b0;
        end else if ((state_q == GRANT_D) && mem_ack) begin
            fair_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, delayed store, contention, reset abort, stray ack.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_gnt;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;

    int n_checks = 0;
    int n_errors = 0;

    bit       exp_d [0:4];
    logic [DW-1:0] exp_drd;
    logic [DW-1:0] exp_ifrd;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_gnt    (if_gnt),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_d_rdata",   d_rdata,   0);
        check("rst_if_gnt",    if_gnt,    0);
        check("rst_d_done",    d_done,    0);
        check("rst_stall",     stall,     0);
        tick();
        tick();
        rst = 1'b0;
        rst = 1'b1;

        // Fetch with immediate ack: pulse on the third cycle.
        if_req  = 1'b1;
        if_addr = 32'h100;
        #1;
        check("f_c1_mem_req", mem_req, 0);
        check("f_c1_stall",   stall,   1);
        tick();
        check("f_c2_mem_req",  mem_req,  1);
        check("f_c2_mem_we",   mem_we,   0);
        check("f_c2_mem_addr", mem_addr, 32'h100);
        check("f_c2_if_gnt",   if_gnt,   0);
        check("f_c2_stall",    stall,    1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0050_0093;
        tick();
        check("f_c3_if_gnt",   if_gnt,   1);
        check("f_c3_d_done",   d_done,   0);
        check("f_c3_if_rdata", if_rdata, 32'h0050_0093);
        check("f_c3_mem_req",  mem_req,  0);
        check("f_c3_stall",    stall,    0);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if_req    = 1'b0;
        tick();
        check("f_c4_if_gnt",  if_gnt,  0);
        check("f_c4_mem_req", mem_req, 0);

        // Store with ack on the fifth grant cycle; request fields change after launch.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hDEAD_BEEF;
        tick();
        d_addr  = 32'h5555_0000;
        d_wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            check("st_mem_req",   mem_req,   1);
            check("st_mem_we",    mem_we,    1);
            check("st_mem_addr",  mem_addr,  32'h2000);
            check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_stall",     stall,     1);
            check("st_d_done",    d_done,    0);
            mem_ack   = (i == 4);
            mem_rdata = (i == 4) ? 32'h1234_5678 : 32'h0;
            tick();
        end
        check("st_resp_d_done",  d_done,  1);
        check("st_resp_if_gnt",  if_gnt,  0);
        check("st_resp_d_rdata", d_rdata, 0);
        check("st_resp_mem_req", mem_req, 0);
        check("st_resp_stall",   stall,   0);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        tick();
        check("st_idle_d_done", d_done, 0);

        // Stray ack in IDLE with nothing pending.
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        check("ia_mem_req",  mem_req,  0);
        check("ia_if_gnt",   if_gnt,   0);
        check("ia_d_done",   d_done,   0);
        tick();
        check("ia2_mem_req",  mem_req,  0);
        check("ia2_if_gnt",   if_gnt,   0);
        check("ia2_d_done",   d_done,   0);
        check("ia2_if_rdata", if_rdata, 32'h0050_0093);
        check("ia2_d_rdata",  d_rdata,  0);
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Both masters held continuously with immediate acks.
`ifdef ARB_FAIR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        exp_drd  = '0;
        exp_ifrd = 32'h0050_0093;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h3000;
        if_req  = 1'b1;
        if_addr = 32'h200;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ct_mem_req",  mem_req,  1);
            check("ct_mem_we",   mem_we,   0);
            check("ct_mem_addr", mem_addr, exp_d[k] ? 32'h3000 : 32'h200);
            mem_ack   = 1'b1;
            mem_rdata = exp_d[k] ? (32'hD000_0000 + k) : (32'h1F00_0000 + k);
            if (exp_d[k]) exp_drd  = 32'hD000_0000 + k;
            else          exp_ifrd = 32'h1F00_0000 + k;
            tick();
            check("ct_d_done",   d_done,   exp_d[k]);
            check("ct_if_gnt",   if_gnt,   !exp_d[k]);
            check("ct_d_rdata",  d_rdata,  exp_drd);
            check("ct_if_rdata", if_rdata, exp_ifrd);
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (k == 3) d_req  = 1'b0;
            if (k == 4) if_req = 1'b0;
            tick();
            check("ct_idle_mem_req", mem_req, 0);
        end

        // Asynchronous reset during a data grant aborts it silently.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h4000;
        tick();
        check("ra_mem_req",  mem_req,  1);
        check("ra_mem_addr", mem_addr, 32'h4000);
        #1;
        rst = 1'b0;
        #1;
        check("ra_now_mem_req",  mem_req,  0);
        check("ra_now_mem_addr", mem_addr, 0);
        check("ra_now_d_done",   d_done,   0);
        check("ra_now_if_rdata", if_rdata, 0);
        check("ra_now_d_rdata",  d_rdata,  0);
        d_req = 1'b0;
        mem_ack = 1'b1;
        tick();
        check("ra_hold_mem_req", mem_req, 0);
        check("ra_hold_d_done",  d_done,  0);
        mem_ack = 1'b0;
        rst     = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h300;
        tick();
        check("ra_f_mem_req",  mem_req,  1);
        check("ra_f_mem_addr", mem_addr, 32'h300);
        check("ra_f_d_done",   d_done,   0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5_5A5A;
        tick();
        check("ra_f_if_gnt",   if_gnt,   1);
        check("ra_f_d_done2",  d_done,   0);
        check("ra_f_if_rdata", if_rdata, 32'hA5A5_5A5A);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if_req    = 1'b0;
        tick();
        check("ra_f_idle_if_gnt", if_gnt,  0);
        check("ra_f_idle_stall",  stall,   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
